fp32_to_int_pipe: RTL and testbench



---
 rtl/fp32_to_int_pipe.sv | 187 ++++++++++++++++++
 tb/tb_fp32_to_int_pipe.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fp32_to_int_pipe.sv
// Three-stage FP32 -> 32-bit integer converter (fcvt.w.s / fcvt.wu.s) with
// a valid/ready elastic pipeline and RISC-V accrued exception flags.
module fp32_to_int_pipe #(
   parameter int TAG_W = 5
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [31:0]      in_a,
   input  logic             in_unsigned,
   input  logic [2:0]       in_rm,
   input  logic [2:0]       in_frm,
   input  logic [TAG_W-1:0] in_tag,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [31:0]      out_data,
   output logic [4:0]       out_fflags,
   output logic [TAG_W-1:0] out_tag
);

   localparam logic [2:0] RM_RTZ = 3'b001;
   localparam logic [2:0] RM_RDN = 3'b010;
   localparam logic [2:0] RM_RUP = 3'b011;
   localparam logic [2:0] RM_RMM = 3'b100;

   // S1 (classify) state
   logic              s1_valid_reg, s1_sign_reg, s1_nan_reg, s1_inf_reg;
   logic              s1_zero_reg, s1_sticky_reg, s1_uns_reg;
   logic [23:0]       s1_m_reg;
   logic signed [8:0] s1_e_reg;
   logic [2:0]        s1_rm_reg;
   logic [TAG_W-1:0]  s1_tag_reg;

   // S2 (align) state
   logic              s2_valid_reg, s2_sign_reg, s2_nan_reg, s2_inf_reg;
   logic              s2_ovf_reg, s2_uns_reg, s2_g_reg, s2_s_reg;
   logic [32:0]       s2_mag_reg;
   logic [2:0]        s2_rm_reg;
   logic [TAG_W-1:0]  s2_tag_reg;

   logic ld1, ld2, ld3;

   // A stage may load when it is empty or its occupant moves on this cycle.
   assign ld3      = !out_valid || out_ready;
   assign ld2      = !s2_valid_reg || ld3;
   assign ld1      = !s1_valid_reg || ld2;
   assign in_ready = ld1;

   logic [7:0]  in_exp;
   logic [22:0] in_frac;
   logic [2:0]  eff_rm;

   assign in_exp  = in_a[30:23];
   assign in_frac = in_a[22:0];
   assign eff_rm  = (in_rm == 3'b111) ? in_frm : in_rm;

   always_ff @(posedge clk) begin
      if (rst) begin
         s1_valid_reg <= 1'b0;
      end else if (ld1) begin
         s1_valid_reg <= in_valid;
         if (in_valid) begin
            s1_sign_reg   <= in_a[31];
            s1_nan_reg    <= (&in_exp) && (|in_frac);
            s1_inf_reg    <= (&in_exp) && !(|in_frac);
            s1_zero_reg   <= !(|in_exp);
            s1_sticky_reg <= |in_frac;
            s1_m_reg      <= {1'b1, in_frac};
            s1_e_reg      <= $signed({1'b0, in_exp}) - 9'sd127;
            s1_uns_reg    <= in_unsigned;
            s1_rm_reg     <= eff_rm;
            s1_tag_reg    <= in_tag;
         end
      end
   end

   logic [54:0] wide;
   logic [32:0] a_mag;
   logic        a_g, a_s, a_ovf;

   always_comb begin
      wide  = {31'b0, s1_m_reg} << s1_e_reg[4:0];
      a_mag = '0;
      a_g   = 1'b0;
      a_s   = 1'b0;
      a_ovf = 1'b0;
      if (s1_nan_reg || s1_inf_reg) begin
         a_ovf = 1'b0;
      end else if (s1_zero_reg) begin
         a_s = s1_sticky_reg;
      end else if (s1_e_reg[8]) begin
         // Below 1.0: the hidden bit is the guard only at exactly e == -1.
         a_g = (s1_e_reg == -9'sd1);
         a_s = (s1_e_reg == -9'sd1) ? (|s1_m_reg[22:0]) : 1'b1;
      end else if (s1_e_reg > 9'sd31) begin
         a_ovf = 1'b1;
      end else begin
         a_mag = {1'b0, wide[54:23]};
         a_g   = wide[22];
         a_s   = |wide[21:0];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         s2_valid_reg <= 1'b0;
      end else if (ld2) begin
         s2_valid_reg <= s1_valid_reg;
         if (s1_valid_reg) begin
            s2_sign_reg <= s1_sign_reg;
            s2_nan_reg  <= s1_nan_reg;
            s2_inf_reg  <= s1_inf_reg;
            s2_ovf_reg  <= a_ovf;
            s2_uns_reg  <= s1_uns_reg;
            s2_g_reg    <= a_g;
            s2_s_reg    <= a_s;
            s2_mag_reg  <= a_mag;
            s2_rm_reg   <= s1_rm_reg;
            s2_tag_reg  <= s1_tag_reg;
         end
      end
   end

   logic        inc, nv, nx;
   logic [32:0] rounded;
   logic [31:0] neg, res;

   always_comb begin
      case (s2_rm_reg)
         RM_RTZ:  inc = 1'b0;
         RM_RDN:  inc = s2_sign_reg && (s2_g_reg || s2_s_reg);
         RM_RUP:  inc = !s2_sign_reg && (s2_g_reg || s2_s_reg);
         RM_RMM:  inc = s2_g_reg;
         default: inc = s2_g_reg && (s2_s_reg || s2_mag_reg[0]);
      endcase
      rounded = s2_mag_reg + {32'b0, inc};
      neg     = ~rounded[31:0] + 32'd1;
      nv      = 1'b0;
      res     = rounded[31:0];
      if (s2_nan_reg) begin
         nv  = 1'b1;
         res = s2_uns_reg ? 32'hFFFF_FFFF : 32'h7FFF_FFFF;
      end else if (s2_inf_reg || s2_ovf_reg) begin
         nv = 1'b1;
         if (s2_uns_reg) res = s2_sign_reg ? 32'h0000_0000 : 32'hFFFF_FFFF;
         else            res = s2_sign_reg ? 32'h8000_0000 : 32'h7FFF_FFFF;
      end else if (s2_uns_reg) begin
         if (s2_sign_reg) begin
            // Negative values that round to zero are exact-zero results, not invalid.
            res = 32'h0000_0000;
            nv  = (rounded != 33'd0);
         end else if (rounded[32]) begin
            res = 32'hFFFF_FFFF;
            nv  = 1'b1;
         end
      end else if (s2_sign_reg) begin
         if (rounded > 33'h0_8000_0000) begin
            res = 32'h8000_0000;
            nv  = 1'b1;
         end else begin
            res = neg;
         end
      end else if (rounded > 33'h0_7FFF_FFFF) begin
         res = 32'h7FFF_FFFF;
         nv  = 1'b1;
      end
      nx = (s2_g_reg || s2_s_reg) && !nv;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid  <= 1'b0;
         out_data   <= '0;
         out_fflags <= '0;
         out_tag    <= '0;
      end else if (ld3) begin
         out_valid <= s2_valid_reg;
         if (s2_valid_reg) begin
            out_data   <= res;
            out_fflags <= {nv, 3'b000, nx};
            out_tag    <= s2_tag_reg;
         end
      end
   end

endmodule

// File: tb/tb_fp32_to_int_pipe.sv
// Self-checking bench for fp32_to_int_pipe: directed cases, backpressure,
// reset flush and randomized traffic against an arithmetic reference model.
module tb_fp32_to_int_pipe;
   localparam int TAG_W = 5;

   logic             clk = 1'b0;
   logic             rst;
   logic             in_valid;
   logic             in_ready;
   logic [31:0]      in_a;
   logic             in_unsigned;
   logic [2:0]       in_rm;
   logic [2:0]       in_frm;
   logic [TAG_W-1:0] in_tag;
   logic             out_valid;
   logic             out_ready;
   logic [31:0]      out_data;
   logic [4:0]       out_fflags;
   logic [TAG_W-1:0] out_tag;

   always #5 clk = ~clk;

   fp32_to_int_pipe #(.TAG_W(TAG_W)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a),
      .in_unsigned(in_unsigned), .in_rm(in_rm), .in_frm(in_frm), .in_tag(in_tag),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .out_fflags(out_fflags), .out_tag(out_tag)
   );

   typedef struct {
      logic [31:0]      d;
      logic [4:0]       f;
      logic [TAG_W-1:0] tag;
      int               acc_cyc;
      bit               lat;
   } exp_t;

   exp_t        q[$];
   int          n_cmp = 0;
   int          n_fail = 0;
   int          cyc = 0;
   bit          hold_prev = 1'b0;
   bit          accepted;
   bit          lat_mode = 1'b0;
   logic [31:0] cur_d;
   logic [4:0]  cur_f;

   logic [31:0] dir_a [17];
   logic        dir_u [17];
   logic [2:0]  dir_rm[17];
   logic [2:0]  dir_fr[17];
   logic [31:0] dir_d [17];
   logic [4:0]  dir_f [17];
   logic [31:0] bp_a  [6];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_cmp++;
      assert (obs === expv) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, expv);
      end
   endtask

   // Reference: exact value m*2^(e-23) split into integer part and remainder,
   // rounded by comparing the remainder with one half, then range-checked.
   function automatic void model(input logic [31:0] a, input logic uns, input logic [2:0] rm_in,
                                 input logic [2:0] frm, output logic [31:0] d, output logic [4:0] f);
      int     rm, ex, e, k;
      longint q_i, rem, half, m, mag, val, lo, hi;
      bit     sign, exact, up, nv;
      sign  = a[31];
      ex    = int'(a[30:23]);
      rm    = (rm_in == 3'd7) ? int'(frm) : int'(rm_in);
      if (rm > 4) rm = 0;
      lo    = uns ? 64'sd0 : -64'sd2147483648;
      hi    = uns ? 64'sd4294967295 : 64'sd2147483647;
      nv    = 1'b0;
      exact = 1'b1;
      d     = 32'd0;
      if (ex == 255) begin
         nv = 1'b1;
         d  = (a[22:0] != 0 || !sign) ? hi[31:0] : lo[31:0];
      end else begin
         q_i  = 0;
         rem  = 0;
         half = 64'sd1 << 40;
         if (ex == 0) begin
            rem = longint'(a[22:0]);
         end else begin
            e = ex - 127;
            m = (64'sd1 << 23) + longint'(a[22:0]);
            if (e >= 40)      q_i = 64'sd1 << 40;
            else if (e >= 23) q_i = m << (e - 23);
            else if (e <= -7) rem = m;
            else begin
               k    = 23 - e;
               q_i  = m >> k;
               rem  = m & ((64'sd1 << k) - 1);
               half = 64'sd1 << (k - 1);
            end
         end
         exact = (rem == 0);
         case (rm)
            0:       up = (rem > half) || (rem == half && q_i[0]);
            1:       up = 1'b0;
            2:       up = !exact && sign;
            3:       up = !exact && !sign;
            default: up = !exact && (rem >= half);
         endcase
         mag = q_i + (up ? 64'sd1 : 64'sd0);
         val = sign ? -mag : mag;
         if (val < lo) begin
            nv = 1'b1; d = lo[31:0];
         end else if (val > hi) begin
            nv = 1'b1; d = hi[31:0];
         end else begin
            d = val[31:0];
         end
      end
      f = {nv, 3'b000, (!exact && !nv)};
   endfunction

   // One clock: sample handshakes on the falling edge, return #1 after the rising edge.
   task automatic step();
      accepted = 1'b0;
      @(negedge clk);
      if (!rst) begin
         chk("in_ready", {31'b0, in_ready}, {31'b0, (q.size() < 3) || out_ready});
         if (out_valid) begin
            if (q.size() == 0) begin
               chk("spurious_out_valid", {31'b0, out_valid}, 32'd0);
            end else begin
               chk("out_data", out_data, q[0].d);
               chk("out_fflags", {27'b0, out_fflags}, {27'b0, q[0].f});
               chk("out_tag", 32'(out_tag), 32'(q[0].tag));
               if (out_ready) begin
                  if (q[0].lat) chk("latency", 32'(cyc - q[0].acc_cyc), 32'd3);
                  void'(q.pop_front());
               end
            end
         end else if (hold_prev) begin
            chk("hold_valid", {31'b0, out_valid}, 32'd1);
         end
         hold_prev = out_valid && !out_ready;
         if (in_valid && in_ready) begin
            q.push_back('{d: cur_d, f: cur_f, tag: in_tag, acc_cyc: cyc, lat: lat_mode});
            accepted = 1'b1;
         end
      end
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic send_op();
      int n;
      in_valid = 1'b1;
      n = 0;
      do begin
         step();
         n++;
      end while (!accepted && n < 20);
      if (!accepted) chk("accept_timeout", 32'(n), 32'd0);
      in_valid = 1'b0;
   endtask

   task automatic drain();
      in_valid  = 1'b0;
      out_ready = 1'b1;
      for (int i = 0; i < 20 && q.size() > 0; i++) step();
      chk("drain_empty", 32'(q.size()), 32'd0);
   endtask

   task automatic gen_random();
      logic       s;
      logic [7:0] ex;
      logic [22:0] fr;
      int         sel;
      s   = 1'($urandom());
      fr  = 23'($urandom());
      sel = $urandom_range(0, 15);
      if (sel == 0) begin
         ex = 8'hFF;
         if ($urandom_range(0, 1) == 0) fr = '0;
      end else if (sel == 1) begin
         ex = 8'h00;
         if ($urandom_range(0, 1) == 0) fr = '0;
      end else begin
         ex = 8'($urandom_range(100, 160));
      end
      in_a        = {s, ex, fr};
      in_unsigned = 1'($urandom());
      in_rm       = 3'($urandom_range(0, 7));
      in_frm      = 3'($urandom_range(0, 6));
      in_tag      = TAG_W'($urandom());
      model(in_a, in_unsigned, in_rm, in_frm, cur_d, cur_f);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      bit have_op;
      int idx;
      dir_a  = '{32'h40200000, 32'h40200000, 32'h40200000, 32'h40200000, 32'hC0200000, 32'hC0200000,
                 32'hCF000000, 32'h4F000000, 32'h4F000000, 32'h4F800000, 32'h7FC00000, 32'h7FC00000,
                 32'hBF800000, 32'hBE800000, 32'h80000000, 32'h3FE00000, 32'h3FE00000};
      dir_u  = '{0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 1, 1, 1, 0, 0, 0};
      dir_rm = '{3'd0, 3'd4, 3'd3, 3'd1, 3'd2, 3'd3, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0,
                 3'd0, 3'd0, 3'd0, 3'd7, 3'd0};
      dir_fr = '{3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0,
                 3'd0, 3'd0, 3'd0, 3'd1, 3'd1};
      dir_d  = '{32'd2, 32'd3, 32'd3, 32'd2, 32'hFFFFFFFD, 32'hFFFFFFFE, 32'h80000000, 32'h7FFFFFFF,
                 32'h80000000, 32'hFFFFFFFF, 32'h7FFFFFFF, 32'hFFFFFFFF, 32'd0, 32'd0, 32'd0,
                 32'd1, 32'd2};
      dir_f  = '{5'h01, 5'h01, 5'h01, 5'h01, 5'h01, 5'h01, 5'h00, 5'h10, 5'h00, 5'h10, 5'h10, 5'h10,
                 5'h10, 5'h01, 5'h00, 5'h01, 5'h01};
      bp_a   = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000, 32'h40A00000, 32'h40C00000};

      rst = 1'b1; in_valid = 1'b0; in_a = '0; in_unsigned = 1'b0; in_rm = '0; in_frm = '0;
      in_tag = '0; out_ready = 1'b0; cur_d = '0; cur_f = '0;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      chk("reset_out_valid", {31'b0, out_valid}, 32'd0);
      chk("reset_out_data", out_data, 32'd0);
      chk("reset_out_fflags", {27'b0, out_fflags}, 32'd0);
      chk("reset_out_tag", 32'(out_tag), 32'd0);
      chk("reset_in_ready", {31'b0, in_ready}, 32'd1);

      // Directed cases, back-to-back with no backpressure.
      lat_mode  = 1'b1;
      out_ready = 1'b1;
      for (int i = 0; i < 17; i++) begin
         in_a = dir_a[i]; in_unsigned = dir_u[i]; in_rm = dir_rm[i]; in_frm = dir_fr[i];
         in_tag = TAG_W'(i); cur_d = dir_d[i]; cur_f = dir_f[i];
         send_op();
      end
      drain();
      lat_mode = 1'b0;

      // Backpressure: six operands, consumer stalls for cycles 2..6.
      idx = 0;
      in_unsigned = 1'b0; in_rm = 3'd0; in_frm = 3'd0;
      for (int c = 0; c < 30 && (idx < 6 || q.size() > 0); c++) begin
         out_ready = !(c >= 2 && c <= 6);
         in_valid  = (idx < 6);
         if (idx < 6) begin
            in_a = bp_a[idx]; in_tag = TAG_W'(idx); cur_d = 32'(idx + 1); cur_f = 5'h00;
         end
         if (c == 4) chk("bp_in_ready_low", {31'b0, in_ready}, 32'd0);
         if (c >= 7 && q.size() > 0) chk("bp_stream_valid", {31'b0, out_valid}, 32'd1);
         step();
         if (accepted) idx++;
      end
      chk("bp_all_sent", 32'(idx), 32'd6);
      drain();

      // Reset with two operations in flight.
      out_ready = 1'b1;
      for (int i = 0; i < 2; i++) begin
         gen_random();
         send_op();
      end
      out_ready = 1'b0;
      rst = 1'b1;
      step();
      rst = 1'b0;
      q.delete();
      hold_prev = 1'b0;
      chk("rst_flush_out_valid", {31'b0, out_valid}, 32'd0);
      chk("rst_flush_in_ready", {31'b0, in_ready}, 32'd1);
      out_ready = 1'b1;
      for (int i = 0; i < 6; i++) begin
         chk("no_stale_result", {31'b0, out_valid}, 32'd0);
         step();
      end

      // Randomized traffic with random backpressure.
      have_op = 1'b0;
      for (int i = 0; i < 600; i++) begin
         if (!have_op) begin
            gen_random();
            have_op = 1'b1;
         end
         in_valid  = ($urandom_range(0, 9) < 8);
         out_ready = ($urandom_range(0, 3) != 0);
         step();
         if (accepted) have_op = 1'b0;
      end
      drain();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
